// File: rtl/can_frame_sequencer_if.sv
// Sample-point bus between the CAN bit-timing front end and the frame sequencer,
// carrying the sampled bit in and the frame context (stuff gate, field, errors) out.
interface can_frame_sequencer_if;
    logic       sp;
    logic       rx_bit;
    logic       is_stuff;
    logic       size_clr;
    logic [3:0] field;
    logic [9:0] bit_pos;
    logic [3:0] dlc;
    logic       frame_done;
    logic       stuff_err;
    logic       form_err;
    logic       ack_seen;

    modport master (
        output sp, rx_bit,
        input  is_stuff, size_clr, field, bit_pos, dlc, frame_done, stuff_err, form_err, ack_seen
    );

    modport slave (
        input  sp, rx_bit,
        output is_stuff, size_clr, field, bit_pos, dlc, frame_done, stuff_err, form_err, ack_seen
    );
endinterface

// File: rtl/can_frame_sequencer.sv
// CAN receive bit sequencer: destuffing, frame field walk, stuff/form error detection.
// Optional extended-identifier support is enabled by defining CAN_EXT_ID_EN.
module can_frame_sequencer #(
    parameter int ERR_IDLE_BITS = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    can_frame_sequencer_if.slave  bus
);
    localparam int ECW = $clog2(ERR_IDLE_BITS + 1);

    typedef enum logic [3:0] {
        F_IDLE    = 4'd0,  F_ID      = 4'd1,  F_RTR_SRR = 4'd2,  F_IDE     = 4'd3,
        F_EXT_ID  = 4'd4,  F_CTRL    = 4'd5,  F_DLC     = 4'd6,  F_DATA    = 4'd7,
        F_CRC     = 4'd8,  F_CRC_DEL = 4'd9,  F_ACK     = 4'd10, F_ACK_DEL = 4'd11,
        F_EOF     = 4'd12, F_IFS     = 4'd13, F_ERR     = 4'd14
    } field_e;

    // Number of DATA bits implied by a DLC/RTR pair; DLC above 8 still means 8 bytes.
    function automatic logic [6:0] data_bits(input logic [3:0] dlc_v, input logic rtr_v);
        logic [3:0] bytes_v;
        bytes_v = (dlc_v > 4'd8) ? 4'd8 : dlc_v;
        return rtr_v ? 7'd0 : {bytes_v, 3'b000};
    endfunction

    field_e         r_field,      w_field;
    logic [6:0]     r_cnt,        w_cnt;
    logic [2:0]     r_run,        w_run;
    logic           r_last,       w_last;
    logic           r_is_stuff,   w_is_stuff;
    logic [9:0]     r_bit_pos,    w_bit_pos;
    logic [3:0]     r_dlc,        w_dlc;
    logic [2:0]     r_dlc_sh,     w_dlc_sh;
    logic           r_rtr,        w_rtr;
    logic           r_ext,        w_ext;
    logic           r_ack_seen,   w_ack_seen;
    logic [ECW-1:0] r_err_cnt,    w_err_cnt;
    logic           r_size_clr,   w_size_clr;
    logic           r_frame_done, w_frame_done;
    logic           r_stuff_err,  w_stuff_err;
    logic           r_form_err,   w_form_err;

    logic           w_fend;
    logic [6:0]     w_cnt_dec;
    logic [6:0]     w_data_len;
    logic           w_sof;
    logic           w_frame_bit;
    logic           w_stuffed;
    logic [2:0]     w_run_inc;

    assign w_fend      = (r_cnt == 7'd1);
    assign w_cnt_dec   = r_cnt - 7'd1;
    assign w_data_len  = data_bits({r_dlc_sh, bus.rx_bit}, r_rtr);
    assign w_sof       = !r_is_stuff && !bus.rx_bit && ((r_field == F_IDLE) || (r_field == F_IFS));
    assign w_frame_bit = (r_field >= F_ID) && (r_field <= F_EOF);
    assign w_stuffed   = (r_field >= F_ID) && (r_field <= F_CRC);
    assign w_run_inc   = (bus.rx_bit == r_last) ? (r_run + 3'd1) : 3'd1;

    // Next-state and output decode, evaluated once per sample point.
    always_comb begin
        w_field      = r_field;
        w_cnt        = r_cnt;
        w_run        = r_run;
        w_last       = r_last;
        w_is_stuff   = r_is_stuff;
        w_bit_pos    = r_bit_pos;
        w_dlc        = r_dlc;
        w_dlc_sh     = r_dlc_sh;
        w_rtr        = r_rtr;
        w_ext        = r_ext;
        w_ack_seen   = r_ack_seen;
        w_err_cnt    = r_err_cnt;
        w_size_clr   = 1'b0;
        w_frame_done = 1'b0;
        w_stuff_err  = 1'b0;
        w_form_err   = 1'b0;

        if (bus.sp && r_is_stuff) begin
            // Stuff bit: must break the run, never counted as a frame bit.
            w_is_stuff = 1'b0;
            if (bus.rx_bit == r_last) begin
                w_stuff_err = 1'b1;
                w_field     = F_ERR;
                w_err_cnt   = {ECW{1'b0}};
            end else begin
                w_run  = 3'd1;
                w_last = bus.rx_bit;
            end
        end else if (bus.sp && w_sof) begin
            w_field    = F_ID;
            w_cnt      = 7'd11;
            w_bit_pos  = 10'd1;
            w_size_clr = 1'b1;
            w_run      = 3'd1;
            w_last     = 1'b0;
            w_ack_seen = 1'b0;
            w_ext      = 1'b0;
            w_is_stuff = 1'b0;
        end else if (bus.sp) begin
            w_bit_pos  = (w_frame_bit && (r_bit_pos != 10'd1023)) ? (r_bit_pos + 10'd1) : r_bit_pos;
            w_run      = w_stuffed ? w_run_inc : r_run;
            w_last     = w_stuffed ? bus.rx_bit : r_last;
            w_is_stuff = w_stuffed && (w_run_inc == 3'd5);
            w_cnt      = w_cnt_dec;
            case (r_field)
                F_IDLE: w_cnt = r_cnt;
                F_ID: begin
                    if (w_fend) begin
                        w_field = F_RTR_SRR;
                        w_cnt   = 7'd1;
                    end else begin
                        w_cnt = w_cnt_dec;
                    end
                end
                F_RTR_SRR: begin
                    // First pass is RTR (base) or SRR (extended); the extended RTR overwrites it.
                    w_rtr = bus.rx_bit;
                    if (r_ext) begin
                        w_field = F_CTRL;
                        w_cnt   = 7'd2;
                    end else begin
                        w_field = F_IDE;
                        w_cnt   = 7'd1;
                    end
                end
                F_IDE: begin
`ifdef CAN_EXT_ID_EN
                    if (bus.rx_bit) begin
                        w_field = F_EXT_ID;
                        w_cnt   = 7'd18;
                        w_ext   = 1'b1;
                    end else begin
                        w_field = F_CTRL;
                        w_cnt   = 7'd1;
                    end
`else
                    if (bus.rx_bit) begin
                        w_form_err = 1'b1;
                        w_field    = F_ERR;
                        w_err_cnt  = {ECW{1'b0}};
                        w_is_stuff = 1'b0;
                    end else begin
                        w_field = F_CTRL;
                        w_cnt   = 7'd1;
                    end
`endif
                end
                F_EXT_ID: begin
                    if (w_fend) begin
                        w_field = F_RTR_SRR;
                        w_cnt   = 7'd1;
                    end else begin
                        w_cnt = w_cnt_dec;
                    end
                end
                F_CTRL: begin
                    if (w_fend) begin
                        w_field = F_DLC;
                        w_cnt   = 7'd4;
                    end else begin
                        w_cnt = w_cnt_dec;
                    end
                end
                F_DLC: begin
                    w_dlc_sh = {r_dlc_sh[1:0], bus.rx_bit};
                    if (w_fend) begin
                        w_dlc = {r_dlc_sh, bus.rx_bit};
                        if (w_data_len == 7'd0) begin
                            w_field = F_CRC;
                            w_cnt   = 7'd15;
                        end else begin
                            w_field = F_DATA;
                            w_cnt   = w_data_len;
                        end
                    end else begin
                        w_cnt = w_cnt_dec;
                    end
                end
                F_DATA: begin
                    if (w_fend) begin
                        w_field = F_CRC;
                        w_cnt   = 7'd15;
                    end else begin
                        w_cnt = w_cnt_dec;
                    end
                end
                F_CRC: begin
                    if (w_fend) begin
                        w_field = F_CRC_DEL;
                        w_cnt   = 7'd1;
                    end else begin
                        w_cnt = w_cnt_dec;
                    end
                end
                F_CRC_DEL: begin
                    if (!bus.rx_bit) begin
                        w_form_err = 1'b1;
                        w_field    = F_ERR;
                        w_err_cnt  = {ECW{1'b0}};
                    end else begin
                        w_field = F_ACK;
                        w_cnt   = 7'd1;
                    end
                end
                F_ACK: begin
                    w_ack_seen = r_ack_seen | ~bus.rx_bit;
                    w_field    = F_ACK_DEL;
                    w_cnt      = 7'd1;
                end
                F_ACK_DEL: begin
                    if (!bus.rx_bit) begin
                        w_form_err = 1'b1;
                        w_field    = F_ERR;
                        w_err_cnt  = {ECW{1'b0}};
                    end else begin
                        w_field = F_EOF;
                        w_cnt   = 7'd7;
                    end
                end
                F_EOF: begin
                    if (!bus.rx_bit) begin
                        w_form_err = 1'b1;
                        w_field    = F_ERR;
                        w_err_cnt  = {ECW{1'b0}};
                    end else if (w_fend) begin
                        w_frame_done = 1'b1;
                        w_field      = F_IFS;
                        w_cnt        = 7'd3;
                    end else begin
                        w_cnt = w_cnt_dec;
                    end
                end
                F_IFS: begin
                    if (w_fend) begin
                        w_field = F_IDLE;
                        w_cnt   = 7'd0;
                    end else begin
                        w_cnt = w_cnt_dec;
                    end
                end
                F_ERR: begin
                    w_cnt = r_cnt;
                    if (!bus.rx_bit) begin
                        w_err_cnt = {ECW{1'b0}};
                    end else if (r_err_cnt == ECW'(ERR_IDLE_BITS - 1)) begin
                        w_err_cnt = {ECW{1'b0}};
                        w_field   = F_IDLE;
                    end else begin
                        w_err_cnt = r_err_cnt + ECW'(1);
                    end
                end
                default: begin
                    w_field = F_ERR;
                    w_cnt   = 7'd0;
                end
            endcase
        end else begin
            w_field = r_field;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_field      <= F_IDLE;
            r_cnt        <= 7'd0;
            r_run        <= 3'd0;
            r_last       <= 1'b0;
            r_is_stuff   <= 1'b0;
            r_bit_pos    <= 10'd0;
            r_dlc        <= 4'd0;
            r_dlc_sh     <= 3'd0;
            r_rtr        <= 1'b0;
            r_ext        <= 1'b0;
            r_ack_seen   <= 1'b0;
            r_err_cnt    <= {ECW{1'b0}};
            r_size_clr   <= 1'b0;
            r_frame_done <= 1'b0;
            r_stuff_err  <= 1'b0;
            r_form_err   <= 1'b0;
        end else begin
            r_field      <= w_field;
            r_cnt        <= w_cnt;
            r_run        <= w_run;
            r_last       <= w_last;
            r_is_stuff   <= w_is_stuff;
            r_bit_pos    <= w_bit_pos;
            r_dlc        <= w_dlc;
            r_dlc_sh     <= w_dlc_sh;
            r_rtr        <= w_rtr;
            r_ext        <= w_ext;
            r_ack_seen   <= w_ack_seen;
            r_err_cnt    <= w_err_cnt;
            r_size_clr   <= w_size_clr;
            r_frame_done <= w_frame_done;
            r_stuff_err  <= w_stuff_err;
            r_form_err   <= w_form_err;
        end
    end

    assign bus.is_stuff   = r_is_stuff;
    assign bus.size_clr   = r_size_clr;
    assign bus.field      = r_field;
    assign bus.bit_pos    = r_bit_pos;
    assign bus.dlc        = r_dlc;
    assign bus.frame_done = r_frame_done;
    assign bus.stuff_err  = r_stuff_err;
    assign bus.form_err   = r_form_err;
    assign bus.ack_seen   = r_ack_seen;
endmodule

// File: tb/tb_can_frame_sequencer.sv
// Self-checking bench for can_frame_sequencer: frames are built bit-by-bit from CAN field
// rules with a queue-based stuffing model; table, hand-written and random frames are checked.
module tb_can_frame_sequencer;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    bit   stream[$];
    bit   is_stf[$];
    int   d2s[$];
    int   region_len;

    typedef struct {
        bit [10:0] id;
        bit        rtr;
        bit [3:0]  dlc;
        bit [63:0] data;
        bit        ack;
        int        exp_pos;
        int        exp_dlc;
        int        exp_ack;
    } vec_t;
    vec_t vecs[5];

    bit [10:0] rid;
    bit        rrtr;
    bit [3:0]  rdlc;
    bit [63:0] rdata;
    bit        rack;
    int        rnb;
    int        fd;

    can_frame_sequencer_if bus ();

    can_frame_sequencer #(.ERR_IDLE_BITS(11)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One sample point; outputs are stable on return (cycle after sp).
    task automatic send_bit(input bit b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        bus.sp     = 1'b1;
        bus.rx_bit = b;
        @(negedge clk);
        bus.sp     = 1'b0;
        bus.rx_bit = 1'($urandom_range(0, 1));
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // Build a complete frame: destuffed field list, CRC-15, stuffing, then fixed-form tail.
    task automatic build_frame(input bit [10:0] bid, input bit ide, input bit [17:0] eid,
                               input bit rtr, input bit [3:0] dlc, input bit [63:0] data,
                               input bit ack);
        bit        d[$];
        bit [14:0] crc;
        int        nbytes;
        int        run;
        bit        last;
        bit        nxt;
        bit        tb;
        d.push_back(1'b0);
        for (int i = 10; i >= 0; i--) d.push_back(bid[i]);
        if (ide) begin
            d.push_back(1'b1);
            d.push_back(1'b1);
            for (int i = 17; i >= 0; i--) d.push_back(eid[i]);
        end
        d.push_back(rtr);
        if (!ide) d.push_back(1'b0);
        d.push_back(1'b0);
        if (ide) d.push_back(1'b0);
        for (int i = 3; i >= 0; i--) d.push_back(dlc[i]);
        nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nbytes * 8; i++) d.push_back(data[63 - i]);
        crc = 15'd0;
        foreach (d[i]) begin
            nxt = d[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nxt) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) d.push_back(crc[i]);

        stream.delete();
        is_stf.delete();
        d2s.delete();
        run  = 0;
        last = 1'b0;
        foreach (d[i]) begin
            if (run == 5) begin
                stream.push_back(!last);
                is_stf.push_back(1'b1);
                last = !last;
                run  = 1;
            end
            d2s.push_back(stream.size());
            stream.push_back(d[i]);
            is_stf.push_back(1'b0);
            run  = (i > 0 && d[i] == last) ? run + 1 : 1;
            last = d[i];
        end
        if (run == 5) begin
            stream.push_back(!last);
            is_stf.push_back(1'b1);
        end
        region_len = stream.size();
        for (int i = 0; i < 10; i++) begin
            tb = (i == 1) ? ack : 1'b1;
            d2s.push_back(stream.size());
            stream.push_back(tb);
            is_stf.push_back(1'b0);
        end
    endtask

    // Send the built frame and check stuff gating per bit plus the end-of-frame context.
    task automatic run_frame(input string tag, input int exp_pos, input int exp_dlc, input int exp_ack);
        int done_cnt;
        int err_cnt;
        bit exp_stf;
        done_cnt = 0;
        err_cnt  = 0;
        for (int k = 0; k < stream.size(); k++) begin
            send_bit(stream[k]);
            exp_stf = (k + 1 < stream.size()) ? is_stf[k + 1] : 1'b0;
            check($sformatf("%s is_stuff@%0d", tag, k), 32'(bus.is_stuff), 32'(exp_stf));
            if (k == 0) begin
                check({tag, " size_clr"}, 32'(bus.size_clr), 32'd1);
                check({tag, " sof bit_pos"}, 32'(bus.bit_pos), 32'd1);
                check({tag, " sof field"}, 32'(bus.field), 32'd1);
            end
            if (bus.stuff_err || bus.form_err) err_cnt++;
            if (bus.frame_done) done_cnt++;
        end
        check({tag, " frame_done last"}, 32'(bus.frame_done), 32'd1);
        check({tag, " bit_pos"}, 32'(bus.bit_pos), 32'(exp_pos));
        check({tag, " dlc"}, 32'(bus.dlc), 32'(exp_dlc));
        check({tag, " ack_seen"}, 32'(bus.ack_seen), 32'(exp_ack));
        check({tag, " field ifs"}, 32'(bus.field), 32'd13);
        check({tag, " done count"}, 32'(done_cnt), 32'd1);
        check({tag, " err pulses"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        bus.sp     = 1'b0;
        bus.rx_bit = 1'b1;

        vecs[0] = '{11'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, 1'b0, 52,  1, 1};
        vecs[1] = '{11'h7F0, 1'b0, 4'd9, 64'h0011_2233_4455_6677, 1'b0, 108, 9, 1};
        vecs[2] = '{11'h2A5, 1'b1, 4'd4, 64'h0,                   1'b0, 44,  4, 1};
        vecs[3] = '{11'h000, 1'b0, 4'd0, 64'h0,                   1'b1, 44,  0, 0};
        vecs[4] = '{11'h7FF, 1'b0, 4'd8, 64'hFFFF_FFFF_0000_0000, 1'b0, 108, 8, 1};

        repeat (3) @(negedge clk);
        check("rst field", 32'(bus.field), 32'd0);
        check("rst bit_pos", 32'(bus.bit_pos), 32'd0);
        check("rst dlc", 32'(bus.dlc), 32'd0);
        check("rst is_stuff", 32'(bus.is_stuff), 32'd0);
        check("rst size_clr", 32'(bus.size_clr), 32'd0);
        check("rst frame_done", 32'(bus.frame_done), 32'd0);
        check("rst stuff_err", 32'(bus.stuff_err), 32'd0);
        check("rst form_err", 32'(bus.form_err), 32'd0);
        check("rst ack_seen", 32'(bus.ack_seen), 32'd0);
        reset_n = 1'b1;
        send_ones(3);
        check("idle recessive", 32'(bus.field), 32'd0);

        for (int v = 0; v < 5; v++) begin
            build_frame(vecs[v].id, 1'b0, 18'd0, vecs[v].rtr, vecs[v].dlc, vecs[v].data, vecs[v].ack);
            run_frame($sformatf("vec%0d", v), vecs[v].exp_pos, vecs[v].exp_dlc, vecs[v].exp_ack);
            send_ones(3);
            check($sformatf("vec%0d idle", v), 32'(bus.field), 32'd0);
        end

        // Stuff error: SOF plus dominant bits, then ERR recovery with a restart.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        check("serr is_stuff before 5th", 32'(bus.is_stuff), 32'd0);
        send_bit(1'b0);
        check("serr is_stuff after 5th", 32'(bus.is_stuff), 32'd1);
        send_bit(1'b0);
        check("serr stuff_err", 32'(bus.stuff_err), 32'd1);
        check("serr form_err", 32'(bus.form_err), 32'd0);
        check("serr field", 32'(bus.field), 32'd14);
        check("serr is_stuff cleared", 32'(bus.is_stuff), 32'd0);
        send_ones(5);
        check("serr pulse cleared", 32'(bus.stuff_err), 32'd0);
        send_bit(1'b0);
        send_ones(10);
        check("serr field after 10", 32'(bus.field), 32'd14);
        send_bit(1'b1);
        check("serr field after 11", 32'(bus.field), 32'd0);

        // Form error on CRC delimiter.
        build_frame(vecs[0].id, 1'b0, 18'd0, vecs[0].rtr, vecs[0].dlc, vecs[0].data, vecs[0].ack);
        fd = 0;
        for (int k = 0; k < region_len; k++) begin
            send_bit(stream[k]);
            if (bus.frame_done) fd++;
        end
        send_bit(1'b0);
        check("ferr form_err", 32'(bus.form_err), 32'd1);
        check("ferr stuff_err", 32'(bus.stuff_err), 32'd0);
        check("ferr field", 32'(bus.field), 32'd14);
        send_bit(1'b1);
        check("ferr pulse cleared", 32'(bus.form_err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1);
            if (bus.frame_done) fd++;
        end
        check("ferr recovered", 32'(bus.field), 32'd0);
        check("ferr no frame_done", 32'(fd), 32'd0);

        // Asynchronous reset in the middle of DATA.
        build_frame(vecs[0].id, 1'b0, 18'd0, vecs[0].rtr, vecs[0].dlc, vecs[0].data, vecs[0].ack);
        for (int k = 0; k < d2s[22]; k++) send_bit(stream[k]);
        check("mid field data", 32'(bus.field), 32'd7);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst field", 32'(bus.field), 32'd0);
        check("arst bit_pos", 32'(bus.bit_pos), 32'd0);
        check("arst dlc", 32'(bus.dlc), 32'd0);
        check("arst is_stuff", 32'(bus.is_stuff), 32'd0);
        check("arst ack_seen", 32'(bus.ack_seen), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arst release size_clr", 32'(bus.size_clr), 32'd0);
        check("arst release frame_done", 32'(bus.frame_done), 32'd0);
        run_frame("after_rst", 52, 1, 1);
        send_ones(3);

        // Back-to-back frames: SOF on the second IFS bit.
        build_frame(vecs[2].id, 1'b0, 18'd0, vecs[2].rtr, vecs[2].dlc, vecs[2].data, vecs[2].ack);
        run_frame("ifs_a", 44, 4, 1);
        send_bit(1'b1);
        check("ifs first bit field", 32'(bus.field), 32'd13);
        run_frame("ifs_b", 44, 4, 1);
        send_ones(3);

        // Extended frame, zero data.
        build_frame(11'h0A5, 1'b1, 18'h25A5A, 1'b0, 4'd0, 64'h0, 1'b0);
`ifdef CAN_EXT_ID_EN
        run_frame("ext", 64, 0, 1);
        send_ones(3);
`else
        for (int k = 0; k < d2s[13]; k++) send_bit(stream[k]);
        send_bit(stream[d2s[13]]);
        check("ext ide form_err", 32'(bus.form_err), 32'd1);
        check("ext ide field", 32'(bus.field), 32'd14);
        send_ones(11);
        check("ext recovered", 32'(bus.field), 32'd0);
`endif

        // Random base frames with random inter-frame gaps (including SOF inside IFS).
        for (int r = 0; r < 8; r++) begin
            rid   = 11'($urandom_range(0, 2047));
            rrtr  = ($urandom_range(0, 3) == 0);
            rdlc  = 4'($urandom_range(0, 15));
            rdata = {$urandom, $urandom};
            rack  = 1'($urandom_range(0, 1));
            rnb   = rrtr ? 0 : ((rdlc > 4'd8) ? 8 : int'(rdlc));
            build_frame(rid, 1'b0, 18'd0, rrtr, rdlc, rdata, rack);
            run_frame($sformatf("rnd%0d", r), 44 + 8 * rnb, int'(rdlc), rack ? 0 : 1);
            send_ones($urandom_range(0, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
